mem_stage: RTL and testbench

- Load/store unit between the EX result register and writeback in the zerocore 5-stage pipeline.
- Takes one EX result per handshake and passes non-memory ops through with one register of latency.
- Memory ops run a single 64-bit RAM transaction using a req/ack protocol; load data is extracted and sign/zero-extended. Stores get a byte-lane bit mask.
- Holds EX off (ex_ready low) while a transaction is outstanding.

---
 rtl/mem_stage_if.sv | 55 +++++
 rtl/mem_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX-side, RAM-side and writeback signals of the load/store stage.
// Modport slave is the stage itself; modport master is the surrounding pipeline/RAM.
`default_nettype none

interface mem_stage_if #(
    parameter int XLEN = 64
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_load;
    logic            ex_is_store;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_res;
    logic [XLEN-1:0] ex_wdata;
    logic            ex_rd_en;
    logic [4:0]      ex_rd_addr;
    logic [XLEN-1:0] ex_pc;
    logic [31:0]     ex_inst;

    logic            ram_ren;
    logic [XLEN-1:0] ram_raddr;
    logic [XLEN-1:0] ram_rdata;
    logic            ram_wen;
    logic [XLEN-1:0] ram_waddr;
    logic [XLEN-1:0] ram_wmask;
    logic [XLEN-1:0] ram_wdata;
    logic            ram_ack;

    logic            wb_valid;
    logic            wb_rd_en;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_inst;
    logic            wb_exc;
    logic            bus_err;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_res, ex_wdata,
               ex_rd_en, ex_rd_addr, ex_pc, ex_inst, ram_rdata, ram_ack,
        output ex_ready, ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wmask,
               ram_wdata, wb_valid, wb_rd_en, wb_rd_addr, wb_data, wb_pc,
               wb_inst, wb_exc, bus_err
    );

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_res, ex_wdata,
               ex_rd_en, ex_rd_addr, ex_pc, ex_inst, ram_rdata, ram_ack,
        input  ex_ready, ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wmask,
               ram_wdata, wb_valid, wb_rd_en, wb_rd_addr, wb_data, wb_pc,
               wb_inst, wb_exc, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: zerocore load/store stage (EX -> RAM req/ack -> writeback), async active-low reset.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W/D accesses trap instead of being rounded down.
`default_nettype none

module mem_stage #(
    parameter int XLEN        = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] c_cnt_last = 8'(ACK_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic            r_rd_en;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [7:0]      r_cnt;

    logic            r_ram_ren;
    logic            r_ram_wen;
    logic [XLEN-1:0] r_ram_wmask;
    logic [XLEN-1:0] r_ram_wdata;

    logic            r_wb_valid;
    logic            r_wb_rd_en;
    logic [4:0]      r_wb_rd_addr;
    logic [XLEN-1:0] r_wb_data;
    logic [XLEN-1:0] r_wb_pc;
    logic [31:0]     r_wb_inst;
    logic            r_bus_err;

    logic [2:0]      w_off;
    logic            w_fire;
    logic            w_is_mem;
    logic            w_misal;
    logic            w_start;
    logic            w_done;
    logic            w_timeout;
    logic [XLEN-1:0] w_wmask;
    logic [XLEN-1:0] w_wdata;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_ldata;

    assign w_off    = bus.ex_res[2:0];
    assign w_fire   = bus.ex_valid && (r_state == IDLE);
    // Load wins when both flags are set; an illegal funct3 degrades to pass-through.
    assign w_is_mem = bus.ex_is_load ? (bus.ex_funct3 != 3'b111)
                                     : (bus.ex_is_store && !bus.ex_funct3[2]);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        w_misal = 1'b0;
        case (bus.ex_funct3[1:0])
            2'd1:    w_misal = w_off[0];
            2'd2:    w_misal = |w_off[1:0];
            2'd3:    w_misal = |w_off;
            default: w_misal = 1'b0;
        endcase
    end
`else
    assign w_misal = 1'b0;
`endif

    // Store lane mask and replicated data; the offset is rounded down to the access size.
    always_comb begin
        w_wmask = '1;
        w_wdata = bus.ex_wdata;
        case (bus.ex_funct3[1:0])
            2'd0: begin
                w_wmask = 64'hFF << {w_off, 3'b000};
                w_wdata = {8{bus.ex_wdata[7:0]}};
            end
            2'd1: begin
                w_wmask = 64'hFFFF << {w_off[2:1], 4'b0000};
                w_wdata = {4{bus.ex_wdata[15:0]}};
            end
            2'd2: begin
                w_wmask = 64'hFFFF_FFFF << {w_off[2], 5'b00000};
                w_wdata = {2{bus.ex_wdata[31:0]}};
            end
            default: begin
                w_wmask = '1;
                w_wdata = bus.ex_wdata;
            end
        endcase
    end

    always_comb begin
        w_shamt = 6'd0;
        case (r_funct3[1:0])
            2'd0:    w_shamt = {r_addr[2:0], 3'b000};
            2'd1:    w_shamt = {r_addr[2:1], 4'b0000};
            2'd2:    w_shamt = {r_addr[2], 5'b00000};
            default: w_shamt = 6'd0;
        endcase
    end

    assign w_shifted = bus.ram_rdata >> w_shamt;

    always_comb begin
        w_ldata = w_shifted;
        case (r_funct3)
            3'b000:  w_ldata = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b100:  w_ldata = {56'd0,               w_shifted[7:0]};
            3'b001:  w_ldata = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_ldata = {48'd0,               w_shifted[15:0]};
            3'b010:  w_ldata = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b110:  w_ldata = {32'd0,               w_shifted[31:0]};
            default: w_ldata = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire && w_is_mem && !w_misal) begin
                    w_start     = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.ram_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_load    <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= 5'd0;
            r_pc         <= '0;
            r_inst       <= 32'd0;
            r_cnt        <= 8'd0;
            r_ram_ren    <= 1'b0;
            r_ram_wen    <= 1'b0;
            r_ram_wmask  <= '0;
            r_ram_wdata  <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd_en   <= 1'b0;
            r_wb_rd_addr <= 5'd0;
            r_wb_data    <= '0;
            r_wb_pc      <= '0;
            r_wb_inst    <= 32'd0;
            r_bus_err    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_start) begin
                r_is_load   <= bus.ex_is_load;
                r_funct3    <= bus.ex_funct3;
                r_addr      <= bus.ex_res;
                r_rd_en     <= bus.ex_rd_en && (bus.ex_rd_addr != 5'd0);
                r_rd_addr   <= bus.ex_rd_addr;
                r_pc        <= bus.ex_pc;
                r_inst      <= bus.ex_inst;
                r_cnt       <= 8'd0;
                r_ram_ren   <= bus.ex_is_load;
                r_ram_wen   <= !bus.ex_is_load;
                r_ram_wmask <= bus.ex_is_load ? '0 : w_wmask;
                r_ram_wdata <= w_wdata;
            end else if (w_fire) begin
                // Pass-through, illegal mem op, or misaligned trap.
                r_wb_valid   <= 1'b1;
                r_wb_data    <= bus.ex_res;
                r_wb_rd_en   <= bus.ex_rd_en && (bus.ex_rd_addr != 5'd0)
                                && !bus.ex_is_load && !bus.ex_is_store;
                r_wb_rd_addr <= bus.ex_rd_addr;
                r_wb_pc      <= bus.ex_pc;
                r_wb_inst    <= bus.ex_inst;
            end else if (w_done || w_timeout) begin
                r_ram_ren    <= 1'b0;
                r_ram_wen    <= 1'b0;
                r_ram_wmask  <= '0;
                r_wb_valid   <= 1'b1;
                r_wb_data    <= (w_done && r_is_load) ? w_ldata : '0;
                r_wb_rd_en   <= w_done && r_is_load && r_rd_en;
                r_wb_rd_addr <= r_rd_addr;
                r_wb_pc      <= r_pc;
                r_wb_inst    <= r_inst;
                if (w_timeout) r_bus_err <= 1'b1;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_wb_exc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_wb_exc <= 1'b0;
        else if (w_fire) r_wb_exc <= w_is_mem && w_misal;
        else             r_wb_exc <= 1'b0;
    end

    assign bus.wb_exc = r_wb_exc;
`else
    assign bus.wb_exc = 1'b0;
`endif

    assign bus.ex_ready   = (r_state == IDLE);
    assign bus.ram_ren    = r_ram_ren;
    assign bus.ram_raddr  = {r_addr[XLEN-1:3], 3'b000};
    assign bus.ram_wen    = r_ram_wen;
    assign bus.ram_waddr  = {r_addr[XLEN-1:3], 3'b000};
    assign bus.ram_wmask  = r_ram_wmask;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd_en   = r_wb_rd_en;
    assign bus.wb_rd_addr = r_wb_rd_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_pc      = r_wb_pc;
    assign bus.wb_inst    = r_wb_inst;
    assign bus.bus_err    = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with hand-computed expectations.
`default_nettype none

module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.XLEN(64)) bus();

    mem_stage #(.XLEN(64), .ACK_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge (always accepted: callers only issue in IDLE).
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rd);
        bus.ex_valid    = 1'b1;
        bus.ex_is_load  = ld;
        bus.ex_is_store = st;
        bus.ex_funct3   = f3;
        bus.ex_res      = res;
        bus.ex_wdata    = wd;
        bus.ex_rd_en    = 1'b1;
        bus.ex_rd_addr  = rd;
        step();
        bus.ex_valid    = 1'b0;
    endtask

    initial begin
        bus.ex_valid    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_is_store = 1'b0;
        bus.ex_funct3   = 3'd0;
        bus.ex_res      = '0;
        bus.ex_wdata    = '0;
        bus.ex_rd_en    = 1'b0;
        bus.ex_rd_addr  = 5'd0;
        bus.ex_pc       = 64'h100;
        bus.ex_inst     = 32'h0000_0013;
        bus.ram_rdata   = '0;
        bus.ram_ack     = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_ex_ready", 64'(bus.ex_ready), 64'd1);
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_ram_ren",  64'(bus.ram_ren),  64'd0);
        check("rst_ram_wen",  64'(bus.ram_wen),  64'd0);
        check("rst_bus_err",  64'(bus.bus_err),  64'd0);
        check("rst_wb_data",  bus.wb_data,       64'd0);
        rst = 1'b1;
        step();

        // Pass-through, rd=5 then rd=0
        issue(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5);
        check("pt_valid", 64'(bus.wb_valid),   64'd1);
        check("pt_data",  bus.wb_data,         64'h1234);
        check("pt_rd_en", 64'(bus.wb_rd_en),   64'd1);
        check("pt_rd",    64'(bus.wb_rd_addr), 64'd5);
        check("pt_pc",    bus.wb_pc,           64'h100);
        issue(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd0);
        check("pt0_valid", 64'(bus.wb_valid), 64'd1);
        check("pt0_rd_en", 64'(bus.wb_rd_en), 64'd0);
        step();
        check("pt_pulse", 64'(bus.wb_valid), 64'd0);

        // Illegal load funct3 -> pass-through without register write
        issue(1'b1, 1'b0, 3'b111, 64'h55, 64'd0, 5'd3);
        check("ill_valid", 64'(bus.wb_valid), 64'd1);
        check("ill_rd_en", 64'(bus.wb_rd_en), 64'd0);
        check("ill_data",  bus.wb_data,       64'h55);
        check("ill_ren",   64'(bus.ram_ren),  64'd0);

        // LB at 0x8003, ack on second ACCESS cycle
        issue(1'b1, 1'b0, 3'b000, 64'h8003, 64'd0, 5'd6);
        check("lb_ren",   64'(bus.ram_ren),  64'd1);
        check("lb_raddr", bus.ram_raddr,     64'h8000);
        check("lb_ready", 64'(bus.ex_ready), 64'd0);
        step();
        check("lb_ready2", 64'(bus.ex_ready), 64'd0);
        check("lb_wait",   64'(bus.wb_valid), 64'd0);
        bus.ram_rdata = 64'h0000_0000_8000_0000;
        bus.ram_ack   = 1'b1;
        step();
        bus.ram_ack   = 1'b0;
        check("lb_valid", 64'(bus.wb_valid), 64'd1);
        check("lb_data",  bus.wb_data,       64'hFFFF_FFFF_FFFF_FF80);
        check("lb_rd_en", 64'(bus.wb_rd_en), 64'd1);
        check("lb_ren_0", 64'(bus.ram_ren),  64'd0);

        // LBU, immediate ack
        issue(1'b1, 1'b0, 3'b100, 64'h8003, 64'd0, 5'd6);
        bus.ram_ack = 1'b1;
        step();
        bus.ram_ack = 1'b0;
        check("lbu_data", bus.wb_data, 64'h80);

        // SH at 0x1006
        issue(1'b0, 1'b1, 3'b001, 64'h1006, 64'hABCD, 5'd7);
        check("sh_wen",   64'(bus.ram_wen),  64'd1);
        check("sh_ren",   64'(bus.ram_ren),  64'd0);
        check("sh_waddr", bus.ram_waddr,     64'h1000);
        check("sh_mask",  bus.ram_wmask,     64'hFFFF_0000_0000_0000);
        check("sh_wdata", bus.ram_wdata,     64'hABCD_ABCD_ABCD_ABCD);
        bus.ram_ack = 1'b1;
        step();
        bus.ram_ack = 1'b0;
        check("sh_valid",  64'(bus.wb_valid), 64'd1);
        check("sh_rd_en",  64'(bus.wb_rd_en), 64'd0);
        check("sh_mask_0", bus.ram_wmask,     64'd0);

        // LW at 0x2002: trap with the feature, rounded-down lower word without
        bus.ram_rdata = 64'h1111_2222_3333_4444;
        issue(1'b1, 1'b0, 3'b010, 64'h2002, 64'd0, 5'd8);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lwm_ren",   64'(bus.ram_ren),  64'd0);
        check("lwm_valid", 64'(bus.wb_valid), 64'd1);
        check("lwm_exc",   64'(bus.wb_exc),   64'd1);
        check("lwm_rd_en", 64'(bus.wb_rd_en), 64'd0);
        check("lwm_data",  bus.wb_data,       64'h2002);
`else
        check("lwm_raddr", bus.ram_raddr, 64'h2000);
        bus.ram_ack = 1'b1;
        step();
        bus.ram_ack = 1'b0;
        check("lwm_data", bus.wb_data,      64'h3333_4444);
        check("lwm_exc",  64'(bus.wb_exc),  64'd0);
`endif

        // LW at 0x2004: upper word, sign-extended
        bus.ram_rdata = 64'h8765_4321_0000_0000;
        issue(1'b1, 1'b0, 3'b010, 64'h2004, 64'd0, 5'd8);
        bus.ram_ack = 1'b1;
        step();
        bus.ram_ack = 1'b0;
        check("lw_hi_data", bus.wb_data, 64'hFFFF_FFFF_8765_4321);

        // LD timeout with ACK_TIMEOUT=4
        issue(1'b1, 1'b0, 3'b011, 64'h3000, 64'd0, 5'd9);
        step();
        step();
        step();
        check("to_ren_held", 64'(bus.ram_ren),  64'd1);
        check("to_no_wb",    64'(bus.wb_valid), 64'd0);
        step();
        check("to_ren_drop", 64'(bus.ram_ren),  64'd0);
        check("to_valid",    64'(bus.wb_valid), 64'd1);
        check("to_rd_en",    64'(bus.wb_rd_en), 64'd0);
        check("to_bus_err",  64'(bus.bus_err),  64'd1);
        step();
        check("to_sticky",   64'(bus.bus_err),  64'd1);
        check("to_ready",    64'(bus.ex_ready), 64'd1);

        // Asynchronous reset in the middle of an access
        issue(1'b1, 1'b0, 3'b010, 64'h4000, 64'd0, 5'd10);
        check("ra_ren", 64'(bus.ram_ren), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ra_ren_async", 64'(bus.ram_ren), 64'd0);
        step();
        step();
        check("ra_no_wb",  64'(bus.wb_valid), 64'd0);
        check("ra_ready",  64'(bus.ex_ready), 64'd1);
        check("ra_berr_0", 64'(bus.bus_err),  64'd0);
        rst = 1'b1;
        step();
        bus.ram_rdata = 64'h0000_007F_0000_0000;
        issue(1'b1, 1'b0, 3'b010, 64'h4004, 64'd0, 5'd10);
        check("ra_lw_ren", 64'(bus.ram_ren), 64'd1);
        bus.ram_ack = 1'b1;
        step();
        bus.ram_ack = 1'b0;
        check("ra_lw_valid", 64'(bus.wb_valid),   64'd1);
        check("ra_lw_data",  bus.wb_data,         64'h7F);
        check("ra_lw_rd",    64'(bus.wb_rd_addr), 64'd10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
